adma_engine: RTL and testbench

ADMA2 engine for the SD host controller: the consumer of the host-register programming stream (ADMA address, command, block-gap control, transfer-mode registers). A command-register write starts it. It fetches 64-bit descriptors from system memory, follows link descriptors and hands each transfer descriptor to the data mover. It also handles stop-at-block-gap, continue, end-of-chain and error reporting. It sits between the host register file and the system-memory/data-mover side of the ADMA.

---
 rtl/adma_engine_pkg.sv | 21 ++
 rtl/adma_engine_if.sv | 38 +++
 rtl/adma_descriptor_decode.sv | 23 ++
 rtl/adma_engine.sv | 101 ++++++++++
 tb/tb_adma_engine.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adma_engine_pkg.sv
// adma_engine_pkg: state codes, descriptor act codes, attribute bit positions, field offsets and an alignment helper
package adma_engine_pkg;
  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FDS   = 3'd1,
    ST_CADR  = 3'd2,
    ST_TFR   = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;
  localparam int ATTR_VALID = 0;
  localparam int ATTR_END = 1;
  localparam int ATTR_INT = 2;
  localparam int ACT_LSB = 4;
  localparam int LEN_LSB = 16;
  localparam int ADDR_LSB = 32;
  function automatic logic aligned(input logic [31:0] a);
    return a[2:0] == 3'd0;
  endfunction
endpackage

// File: rtl/adma_engine_if.sv
// adma_engine_if: host registers in, descriptor fetch (mem_*), data-mover handoff (tfr_*), status out; master = engine, slave = environment
interface adma_engine_if;
  logic [15:0] adma_address_register_0;
  logic [15:0] adma_address_register_1;
  logic [15:0] adma_address_register_2;
  logic [15:0] adma_address_register_3;
  logic        command_reg_write;
  logic [15:0] transfer_mode_register_in;
  logic [15:0] block_gap_control_register;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        tfr_start;
  logic [31:0] tfr_addr;
  logic [15:0] tfr_length;
  logic        tfr_direction;
  logic        tfr_done;
  logic [2:0]  adma_state;
  logic        adma_int;
  logic        xfer_complete;
  logic        adma_error;
  logic [31:0] desc_ptr;
  modport master (
    input  adma_address_register_0, adma_address_register_1, adma_address_register_2,
           adma_address_register_3, command_reg_write, transfer_mode_register_in,
           block_gap_control_register, mem_ack, mem_rdata, tfr_done,
    output mem_req, mem_addr, tfr_start, tfr_addr, tfr_length, tfr_direction,
           adma_state, adma_int, xfer_complete, adma_error, desc_ptr
  );
  modport slave (
    output adma_address_register_0, adma_address_register_1, adma_address_register_2,
           adma_address_register_3, command_reg_write, transfer_mode_register_in,
           block_gap_control_register, mem_ack, mem_rdata, tfr_done,
    input  mem_req, mem_addr, tfr_start, tfr_addr, tfr_length, tfr_direction,
           adma_state, adma_int, xfer_complete, adma_error, desc_ptr
  );
endinterface

// File: rtl/adma_descriptor_decode.sv
// adma_descriptor_decode: splits a 64-bit ADMA2 descriptor (desc) into valid/last/irq flags, tran/link kind, length and address
module adma_descriptor_decode
  import adma_engine_pkg::*;
(
  input  logic [63:0] desc,
  output logic        valid,
  output logic        last,
  output logic        irq,
  output logic        is_tran,
  output logic        is_link,
  output logic [15:0] length,
  output logic [31:0] address
);
  logic unused;
  assign valid = desc[ATTR_VALID];
  assign last = desc[ATTR_END];
  assign irq = desc[ATTR_INT];
  assign is_tran = desc[ACT_LSB +: 2] == ACT_TRAN;
  assign is_link = desc[ACT_LSB +: 2] == ACT_LINK;
  assign length = desc[LEN_LSB +: 16];
  assign address = desc[ADDR_LSB +: 32];
  assign unused = ^{desc[3], desc[15:6]};
endmodule

// File: rtl/adma_engine.sv
// adma_engine: ADMA2 engine; clk, rst (async, active-high) and bus (master modport) carrying host registers, descriptor fetch, transfer handoff and status
module adma_engine
  import adma_engine_pkg::*;
(
  input logic clk,
  input logic rst,
  adma_engine_if.master bus
);
  state_t state, state_n;
  logic [31:0] ptr, ptr_n, base, address;
  logic [63:0] desc, raw;
  logic [15:0] length;
  logic valid, last, irq, is_tran, is_link;
  logic go, launch, int_n, cmp_n, err_n;
  logic unused;
  assign base = {bus.adma_address_register_1, bus.adma_address_register_0};
  assign go = bus.command_reg_write & bus.transfer_mode_register_in[0];
  assign unused = ^{bus.adma_address_register_2, bus.adma_address_register_3,
                    bus.transfer_mode_register_in[15:5], bus.transfer_mode_register_in[3:1],
                    bus.block_gap_control_register[15:2]};
  assign bus.adma_state = state;
  assign bus.desc_ptr = ptr;
  assign bus.mem_addr = ptr;
  // fetch decodes the word on the bus; later states work from the latched copy
  assign raw = state == ST_FDS ? bus.mem_rdata : desc;
  adma_descriptor_decode u_dec (
    .desc(raw),
    .valid(valid),
    .last(last),
    .irq(irq),
    .is_tran(is_tran),
    .is_link(is_link),
    .length(length),
    .address(address)
  );
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    launch = 1'b0;
    int_n = 1'b0;
    cmp_n = 1'b0;
    err_n = 1'b0;
    case (state)
      ST_STOP: if (go) begin
        ptr_n = base;
        err_n = !aligned(base);
        state_n = aligned(base) ? ST_FDS : ST_STOP;
      end
      ST_FDS: if (bus.mem_ack) begin
        ptr_n = ptr + 32'd8;
        err_n = !valid;
        int_n = valid & irq & !is_tran;
        cmp_n = valid & last & !is_tran;
        launch = valid & is_tran;
        state_n = !valid || (last && !is_tran) ? ST_STOP :
                  is_tran ? ST_TFR : is_link ? ST_CADR : ST_FDS;
      end
      ST_CADR: begin
        ptr_n = address;
        err_n = !aligned(address);
        state_n = aligned(address) ? ST_FDS : ST_STOP;
      end
      ST_TFR: if (bus.tfr_done) begin
        int_n = irq;
        cmp_n = last;
        state_n = last ? ST_STOP : bus.block_gap_control_register[0] ? ST_PAUSE : ST_FDS;
      end
      ST_PAUSE: state_n = bus.block_gap_control_register[1] && !bus.block_gap_control_register[0] ?
                          ST_FDS : ST_PAUSE;
      default: state_n = ST_STOP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_STOP;
      ptr <= '0;
      desc <= '0;
      bus.mem_req <= 1'b0;
      bus.tfr_start <= 1'b0;
      bus.tfr_addr <= '0;
      bus.tfr_length <= '0;
      bus.tfr_direction <= 1'b0;
      bus.adma_int <= 1'b0;
      bus.xfer_complete <= 1'b0;
      bus.adma_error <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      bus.mem_req <= state_n == ST_FDS;
      bus.tfr_start <= launch;
      bus.adma_int <= int_n;
      bus.xfer_complete <= cmp_n;
      bus.adma_error <= err_n;
      if (state == ST_FDS && bus.mem_ack) desc <= bus.mem_rdata;
      if (launch) begin
        bus.tfr_addr <= address;
        bus.tfr_length <= length;
      end
      if (state == ST_STOP && go) bus.tfr_direction <= bus.transfer_mode_register_in[4];
    end
endmodule

// File: tb/tb_adma_engine.sv
// tb_adma_engine: directed timing checks plus random descriptor chains compared against a chain-walking reference model
module tb_adma_engine;
  import adma_engine_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  adma_engine_if bus();
  adma_engine dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [63:0] mem [logic [31:0]];
  int mem_slow = 0;
  int tfr_slow = 0;
  bit mem_en = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] fetch_q[$];
  logic [48:0] tfr_q[$];
  int rise_q[$], ack_q[$], done_q[$];
  int n_int, n_cmp, n_err, int_cyc, cmp_cyc, err_cyc, start_cyc, cmd_cyc;
  bit prev_req = 1'b0;
  logic [31:0] exp_fetch[$];
  logic [48:0] exp_tfr[$];
  int exp_int, exp_cmp, exp_err;
  logic [31:0] exp_ptr;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever @(negedge clk) begin
      bus.mem_ack = 1'b0;
      if (mem_en && bus.mem_req && $urandom_range(0, mem_slow) == 0) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
      end
    end
  end
  initial begin
    int cnt = -1;
    bus.tfr_done = 1'b0;
    forever @(negedge clk) begin
      bus.tfr_done = 1'b0;
      if (bus.tfr_start) cnt = 1 + int'($urandom_range(0, tfr_slow));
      if (cnt == 0) bus.tfr_done = 1'b1;
      if (cnt >= 0) cnt--;
    end
  end
  always @(negedge clk) begin
    #1;
    if (bus.mem_req && !prev_req) rise_q.push_back(cyc);
    prev_req = bus.mem_req;
    if (bus.mem_req && bus.mem_ack) begin
      fetch_q.push_back(bus.mem_addr);
      ack_q.push_back(cyc);
    end
    if (bus.tfr_start) begin
      tfr_q.push_back({bus.tfr_direction, bus.tfr_length, bus.tfr_addr});
      start_cyc = cyc;
    end
    if (bus.tfr_done) done_q.push_back(cyc);
    if (bus.adma_int) begin n_int++; int_cyc = cyc; end
    if (bus.xfer_complete) begin n_cmp++; cmp_cyc = cyc; end
    if (bus.adma_error) begin n_err++; err_cyc = cyc; end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic clear_log();
    fetch_q.delete(); tfr_q.delete(); rise_q.delete(); ack_q.delete(); done_q.delete();
    n_int = 0; n_cmp = 0; n_err = 0;
    int_cyc = -1; cmp_cyc = -1; err_cyc = -1; start_cyc = -1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask
  task automatic start_chain(input logic [31:0] a, input logic d);
    @(negedge clk);
    bus.adma_address_register_0 = a[15:0];
    bus.adma_address_register_1 = a[31:16];
    bus.adma_address_register_2 = 16'($urandom);
    bus.adma_address_register_3 = 16'($urandom);
    bus.transfer_mode_register_in = {11'($urandom), d, 3'($urandom), 1'b1};
    bus.command_reg_write = 1'b1;
    cmd_cyc = cyc;
    @(negedge clk);
    bus.command_reg_write = 1'b0;
  endtask
  task automatic wait_end();
    int k = 0;
    while (n_cmp + n_err == 0 && k < 3000) begin
      tick(1);
      k++;
    end
    check("chain_finished", n_cmp + n_err != 0, 1);
    tick(3);
  endtask
  task automatic wait_done(input int n);
    int k = 0;
    while (done_q.size() < n && k < 500) begin
      tick(1);
      k++;
    end
    check("tfr_done_seen", done_q.size() >= n, 1);
  endtask
  task automatic build_chain(output logic [31:0] s);
    int n, k;
    logic [31:0] a, t;
    logic [63:0] d;
    mem.delete();
    n = $urandom_range(1, 8);
    k = $urandom_range(0, 9);
    a = k == 0 ? 32'hFFFF_FFF0 : k == 1 ? 32'h0000_0014 : 32'($urandom_range(0, 31)) << 3;
    s = a;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      t = 32'h10000 * (i + 1) + (32'($urandom_range(0, 15)) << 3);
      if ($urandom_range(0, 7) == 0) t[2] = 1'b1;
      d = {32'($urandom), 16'($urandom), 10'd0, k < 2 ? 2'(k) : k < 7 ? 2'b10 : 2'b11,
           1'b0, 1'($urandom), i == n - 1, $urandom_range(0, 15) != 0};
      if (d[5:4] == 2'b11) d[63:32] = t;
      mem[a] = d;
      a = d[5:4] == 2'b11 ? t : a + 32'd8;
    end
  endtask
  task automatic run_model(input logic [31:0] s, input logic dir);
    logic [31:0] p;
    logic [63:0] d;
    exp_fetch.delete(); exp_tfr.delete();
    exp_int = 0; exp_cmp = 0; exp_err = 0;
    p = s;
    if (p[2:0] != 0) exp_err = 1;
    else for (int i = 0; i < 64; i++) begin
      d = mem.exists(p) ? mem[p] : 64'h0;
      exp_fetch.push_back(p);
      p = p + 32'd8;
      if (!d[0]) begin exp_err++; break; end
      if (d[2]) exp_int++;
      if (d[5:4] == 2'b10) exp_tfr.push_back({dir, d[31:16], d[63:32]});
      if (d[1]) begin exp_cmp++; break; end
      if (d[5:4] == 2'b11) begin
        p = d[63:32];
        if (p[2:0] != 0) begin exp_err++; break; end
      end
    end
    exp_ptr = p;
  endtask
  task automatic compare_run(input logic [31:0] s);
    check("r_nfetch", fetch_q.size(), exp_fetch.size());
    foreach (exp_fetch[i]) if (i < fetch_q.size()) check("r_fetch", fetch_q[i], exp_fetch[i]);
    check("r_ntfr", tfr_q.size(), exp_tfr.size());
    foreach (exp_tfr[i]) if (i < tfr_q.size()) check("r_tfr", tfr_q[i], exp_tfr[i]);
    check("r_int", n_int, exp_int);
    check("r_cmp", n_cmp, exp_cmp);
    check("r_err", n_err, exp_err);
    check("r_state", bus.adma_state, ST_STOP);
    if (s[2:0] == 0) check("r_ptr", bus.desc_ptr, exp_ptr);
  endtask
  initial begin
    logic [31:0] s;
    logic dir;
    int rel;
    bus.command_reg_write = 1'b0;
    bus.adma_address_register_0 = '0;
    bus.adma_address_register_1 = '0;
    bus.adma_address_register_2 = '0;
    bus.adma_address_register_3 = '0;
    bus.transfer_mode_register_in = '0;
    bus.block_gap_control_register = '0;
    clear_log();
    tick(3);
    check("rst_state", bus.adma_state, ST_STOP);
    check("rst_desc_ptr", bus.desc_ptr, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_tfr_start", bus.tfr_start, 0);
    check("rst_tfr_addr", bus.tfr_addr, 0);
    check("rst_tfr_length", bus.tfr_length, 0);
    check("rst_tfr_dir", bus.tfr_direction, 0);
    check("rst_int", bus.adma_int, 0);
    check("rst_cmp", bus.xfer_complete, 0);
    check("rst_err", bus.adma_error, 0);
    @(negedge clk);
    rst = 1'b0;
    mem.delete();
    mem[32'h0] = 64'h0000_1000_0200_0023;
    clear_log();
    start_chain(32'h0, 1'b0);
    wait_end();
    check("t1_req_latency", (rise_q.size() ? rise_q[0] : -1) - cmd_cyc, 1);
    check("t1_start_latency", start_cyc - (ack_q.size() ? ack_q[0] : -9), 1);
    check("t1_tfr_addr", tfr_q.size() ? tfr_q[0][31:0] : 32'hx, 32'h1000);
    check("t1_tfr_len", tfr_q.size() ? tfr_q[0][47:32] : 16'hx, 16'h0200);
    check("t1_cmp_latency", cmp_cyc - (done_q.size() ? done_q[0] : -9), 1);
    check("t1_ncmp", n_cmp, 1);
    check("t1_state", bus.adma_state, ST_STOP);
    check("t1_ptr", bus.desc_ptr, 32'h8);
    mem.delete();
    mem[32'h0] = 64'h0000_0040_0000_0031;
    mem[32'h40] = 64'h0000_2000_0010_0023;
    clear_log();
    start_chain(32'h0, 1'b1);
    wait_end();
    check("t2_nfetch", fetch_q.size(), 2);
    check("t2_fetch0", fetch_q.size() > 0 ? fetch_q[0] : 32'hx, 32'h0);
    check("t2_fetch1", fetch_q.size() > 1 ? fetch_q[1] : 32'hx, 32'h40);
    check("t2_relink_gap", (rise_q.size() > 1 ? rise_q[1] : -9) - (ack_q.size() ? ack_q[0] : -9), 2);
    check("t2_ptr", bus.desc_ptr, 32'h48);
    check("t2_tfr", tfr_q.size() ? tfr_q[0] : 49'hx, {1'b1, 16'h0010, 32'h2000});
    mem.delete();
    mem[32'h0] = 64'h0000_5000_0100_0022;
    clear_log();
    start_chain(32'h0, 1'b0);
    wait_end();
    check("t3_nerr", n_err, 1);
    check("t3_no_tfr", tfr_q.size(), 0);
    check("t3_err_latency", err_cyc - (ack_q.size() ? ack_q[0] : -9), 1);
    check("t3_state", bus.adma_state, ST_STOP);
    clear_log();
    start_chain(32'h4, 1'b0);
    wait_end();
    check("t3b_nerr", n_err, 1);
    check("t3b_no_req", rise_q.size(), 0);
    check("t3b_err_latency", err_cyc - cmd_cyc, 1);
    mem.delete();
    mem[32'h0] = 64'h0000_3000_0100_0021;
    mem[32'h8] = 64'h0000_3400_0080_0023;
    mem[32'h40] = 64'h0000_7000_0040_0023;
    clear_log();
    bus.block_gap_control_register = 16'h1;
    start_chain(32'h0, 1'b0);
    wait_done(1);
    tick(2);
    check("t4_paused", bus.adma_state, ST_PAUSE);
    check("t4_no_refetch", rise_q.size(), 1);
    start_chain(32'h40, 1'b1);
    @(negedge clk);
    bus.block_gap_control_register = 16'h3;
    tick(3);
    check("t4_still_paused", bus.adma_state, ST_PAUSE);
    check("t4_still_no_req", bus.mem_req, 0);
    @(negedge clk);
    bus.block_gap_control_register = 16'h2;
    rel = cyc;
    wait_end();
    check("t4_release_latency", (rise_q.size() > 1 ? rise_q[1] : -9) - rel, 1);
    check("t4_fetch1", fetch_q.size() > 1 ? fetch_q[1] : 32'hx, 32'h8);
    check("t4_ntfr", tfr_q.size(), 2);
    check("t4_ncmp", n_cmp, 1);
    check("t4_ptr", bus.desc_ptr, 32'h10);
    bus.block_gap_control_register = 16'h0;
    mem.delete();
    mem[32'h40] = 64'h0000_6000_0300_0023;
    clear_log();
    mem_en = 1'b0;
    start_chain(32'h40, 1'b1);
    tick(3);
    check("t5_req_held", bus.mem_req, 1);
    rst = 1'b1;
    #1;
    check("t5_req_async", bus.mem_req, 0);
    check("t5_state_async", bus.adma_state, ST_STOP);
    check("t5_ptr_async", bus.desc_ptr, 0);
    check("t5_dir_async", bus.tfr_direction, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b1;
    clear_log();
    start_chain(32'h40, 1'b1);
    wait_end();
    check("t5_restart_fetch", fetch_q.size() ? fetch_q[0] : 32'hx, 32'h40);
    check("t5_restart_tfr", tfr_q.size() ? tfr_q[0] : 49'hx, {1'b1, 16'h0300, 32'h6000});
    check("t5_restart_cmp", n_cmp, 1);
    mem.delete();
    mem[32'h0] = 64'h0000_8000_0020_0025;
    mem[32'h8] = 64'h0000_0000_0000_0003;
    clear_log();
    start_chain(32'h0, 1'b0);
    wait_end();
    check("t6_nint", n_int, 1);
    check("t6_int_latency", int_cyc - (done_q.size() ? done_q[0] : -9), 1);
    check("t6_cmp_after_fetch", cmp_cyc - (done_q.size() ? done_q[0] : -9), 2);
    check("t6_ncmp", n_cmp, 1);
    mem_slow = 2;
    tfr_slow = 3;
    for (int t = 0; t < 40; t++) begin
      build_chain(s);
      dir = 1'($urandom);
      run_model(s, dir);
      clear_log();
      start_chain(s, dir);
      wait_end();
      compare_run(s);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
